// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: picks one of four writeback requesters per cycle
// and registers the winner's mux select and destination for the following cycle.
module wb_port_arbiter #(
    parameter int RR_ENABLE    = 1,
    parameter int STARVE_LIMIT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [3:0] req,
    input  logic [2:0] src0,
    input  logic [2:0] src1,
    input  logic [2:0] src2,
    input  logic [2:0] src3,
    input  logic [4:0] dst0,
    input  logic [4:0] dst1,
    input  logic [4:0] dst2,
    input  logic [4:0] dst3,
    output logic [3:0] gnt,
    output logic [2:0] mem_to_reg,
    output logic       reg_write,
    output logic [4:0] write_reg,
    output logic       starved
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    function automatic logic [2:0] satInc(input logic [2:0] v);
        return (v >= LIMIT) ? LIMIT : v + 3'd1;
    endfunction

    logic [1:0] ptr;
    logic [2:0] waitCnt [4];
    logic [2:0] nextCnt [4];
    logic [2:0] srcArr  [4];
    logic [4:0] dstArr  [4];
    logic [3:0] starveVec;
    logic [1:0] pickIdx;
    logic [1:0] rrIdx;
    logic       pickValid;
    logic       grantOk;
    logic       anyStarved;
    logic [2:0] selSrc;
    logic [4:0] selDst;

    always_comb begin
        srcArr[0] = src0;
        srcArr[1] = src1;
        srcArr[2] = src2;
        srcArr[3] = src3;
        dstArr[0] = dst0;
        dstArr[1] = dst1;
        dstArr[2] = dst2;
        dstArr[3] = dst3;
        for (int i = 0; i < 4; i++) begin
            starveVec[i] = req[i] && (waitCnt[i] == LIMIT);
        end

        // Descending loops let the lowest index / nearest offset win last.
        pickValid = 1'b0;
        pickIdx   = 2'd0;
        rrIdx     = 2'd0;
        if (|starveVec) begin
            for (int i = 3; i >= 0; i--) begin
                if (starveVec[i]) begin
                    pickValid = 1'b1;
                    pickIdx   = 2'(i);
                end
            end
        end else if (RR_ENABLE != 0) begin
            for (int off = 3; off >= 0; off--) begin
                rrIdx = ptr + 2'(off);
                if (req[rrIdx]) begin
                    pickValid = 1'b1;
                    pickIdx   = rrIdx;
                end
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) begin
                    pickValid = 1'b1;
                    pickIdx   = 2'(i);
                end
            end
        end

        grantOk = pickValid && !hold && reset;
        gnt     = grantOk ? (4'b0001 << pickIdx) : 4'b0000;
        selSrc  = srcArr[pickIdx];
        selDst  = dstArr[pickIdx];

        anyStarved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nextCnt[i] = (!req[i] || gnt[i]) ? 3'd0 : satInc(waitCnt[i]);
            if (nextCnt[i] == LIMIT) anyStarved = 1'b1;
        end
    end

    // Writeback register stage: one cycle after the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= 2'd0;
            mem_to_reg <= 3'd0;
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            starved    <= 1'b0;
            for (int i = 0; i < 4; i++) waitCnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) waitCnt[i] <= nextCnt[i];
            starved <= anyStarved;
            if (grantOk) begin
                ptr        <= pickIdx + 2'd1;
                mem_to_reg <= selSrc;
                write_reg  <= selDst;
                reg_write  <= (selDst != 5'd0);
            end else begin
                reg_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; each task checks its own scenario inline.
module tb_wb_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [2:0] src0 = '0, src1 = '0, src2 = '0, src3 = '0;
    logic [4:0] dst0 = '0, dst1 = '0, dst2 = '0, dst3 = '0;

    logic [3:0] gntR, gntF;
    logic [2:0] mtrR, mtrF;
    logic       rwR, rwF, stR, stF;
    logic [4:0] wrR, wrF;

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.RR_ENABLE(1), .STARVE_LIMIT(7)) dutRr (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3),
        .gnt(gntR), .mem_to_reg(mtrR), .reg_write(rwR), .write_reg(wrR), .starved(stR)
    );

    wb_port_arbiter #(.RR_ENABLE(0), .STARVE_LIMIT(7)) dutFp (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3),
        .gnt(gntF), .mem_to_reg(mtrF), .reg_write(rwF), .write_reg(wrF), .starved(stF)
    );

    // Leaves time at 1 unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; req = 4'b1111;
        src0 = 3'd7; dst0 = 5'd31;
        #2;
        nAssert++;
        if ({gntR, mtrR, rwR, wrR, stR} !== 14'd0) begin
            nFail++;
            $display("FAIL reset_async: outputs=%b required all zero", {gntR, mtrR, rwR, wrR, stR});
        end
        tick();
        tick();
        nAssert++;
        if ({gntR, mtrR, rwR, wrR, stR, gntF, rwF} !== 19'd0) begin
            nFail++;
            $display("FAIL reset_clocked: outputs=%b required all zero",
                     {gntR, mtrR, rwR, wrR, stR, gntF, rwF});
        end
    endtask

    task automatic test_rr_sequence();
        logic [3:0] eg;
        logic [2:0] es;
        logic [4:0] ed;
        reset = 1'b0; hold = 1'b0; req = 4'b1111;
        src0 = 3'd1; src1 = 3'd2; src2 = 3'd3; src3 = 3'd4;
        dst0 = 5'd11; dst1 = 5'd12; dst2 = 5'd13; dst3 = 5'd14;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            es = 3'(k % 4 + 1);
            ed = 5'(11 + k % 4);
            #2;
            nAssert++;
            if (gntR !== eg) begin
                nFail++;
                $display("FAIL rr_gnt[%0d]: gnt=%b required %b", k, gntR, eg);
            end
            tick();
            nAssert++;
            if ({rwR, mtrR, wrR} !== {1'b1, es, ed}) begin
                nFail++;
                $display("FAIL rr_write[%0d]: rw/mtr/wr=%b/%0d/%0d required 1/%0d/%0d",
                         k, rwR, mtrR, wrR, es, ed);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0000;
        tick();
        req = 4'b0100; src2 = 3'b011; dst2 = 5'd9;
        #2;
        nAssert++;
        if (gntR !== 4'b0100) begin
            nFail++;
            $display("FAIL single_gnt: gnt=%b required 0100", gntR);
        end
        tick();
        req = 4'b0000;
        nAssert++;
        if ({rwR, mtrR, wrR} !== {1'b1, 3'b011, 5'd9}) begin
            nFail++;
            $display("FAIL single_write: rw/mtr/wr=%b/%b/%0d required 1/011/9", rwR, mtrR, wrR);
        end
        #2;
        nAssert++;
        if (gntR !== 4'b0000) begin
            nFail++;
            $display("FAIL idle_gnt: gnt=%b required 0000", gntR);
        end
        tick();
        nAssert++;
        if ({rwR, mtrR, wrR} !== {1'b0, 3'b011, 5'd9}) begin
            nFail++;
            $display("FAIL idle_hold: rw/mtr/wr=%b/%b/%0d required 0/011/9", rwR, mtrR, wrR);
        end
    endtask

    task automatic test_zero_dst();
        req = 4'b0001; src0 = 3'b000; dst0 = 5'd0;
        #2;
        nAssert++;
        if (gntR !== 4'b0001) begin
            nFail++;
            $display("FAIL zero_gnt: gnt=%b required 0001", gntR);
        end
        tick();
        req = 4'b0000;
        nAssert++;
        if ({rwR, mtrR, wrR} !== {1'b0, 3'b000, 5'd0}) begin
            nFail++;
            $display("FAIL zero_write: rw/mtr/wr=%b/%b/%0d required 0/000/0", rwR, mtrR, wrR);
        end
    endtask

    task automatic test_hold_starve();
        doReset();
        hold = 1'b1; req = 4'b1000; src3 = 3'd6; dst3 = 5'd21; src0 = 3'd1; dst0 = 5'd3;
        for (int c = 1; c <= 8; c++) begin
            #2;
            nAssert++;
            if ({gntR, stR} !== {4'b0000, (c >= 8)}) begin
                nFail++;
                $display("FAIL hold_cycle[%0d]: gnt/starved=%b/%b required 0000/%b",
                         c, gntR, stR, (c >= 8));
            end
            tick();
        end
        hold = 1'b0; req = 4'b1001;
        #2;
        nAssert++;
        if (gntR !== 4'b1000) begin
            nFail++;
            $display("FAIL starve_override: gnt=%b required 1000", gntR);
        end
        tick();
        req = 4'b0001;
        nAssert++;
        if ({rwR, mtrR, wrR, stR} !== {1'b1, 3'd6, 5'd21, 1'b0}) begin
            nFail++;
            $display("FAIL starve_write: rw/mtr/wr/starved=%b/%0d/%0d/%b required 1/6/21/0",
                     rwR, mtrR, wrR, stR);
        end
        #2;
        nAssert++;
        if (gntR !== 4'b0001) begin
            nFail++;
            $display("FAIL after_starve: gnt=%b required 0001", gntR);
        end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_fixed_priority();
        logic [3:0] ef;
        logic [3:0] er;
        doReset();
        hold = 1'b0; req = 4'b0110;
        src1 = 3'd2; dst1 = 5'd5; src2 = 3'd5; dst2 = 5'd7;
        for (int c = 1; c <= 9; c++) begin
            ef = (c == 8) ? 4'b0100 : 4'b0010;
            er = (c % 2 == 1) ? 4'b0010 : 4'b0100;
            if (c == 4) begin
                nAssert++;
                if (dutFp.waitCnt[2] !== 3'd3) begin
                    nFail++;
                    $display("FAIL fp_wait_count: count=%0d required 3", dutFp.waitCnt[2]);
                end
            end
            nAssert++;
            if (stF !== (c == 8)) begin
                nFail++;
                $display("FAIL fp_starved[%0d]: starved=%b required %b", c, stF, (c == 8));
            end
            #2;
            nAssert++;
            if ({gntF, gntR} !== {ef, er}) begin
                nFail++;
                $display("FAIL fp_rr_gnt[%0d]: fp=%b rr=%b required fp=%b rr=%b",
                         c, gntF, gntR, ef, er);
            end
            tick();
            if (c == 8) begin
                nAssert++;
                if ({rwF, mtrF, wrF} !== {1'b1, 3'd5, 5'd7}) begin
                    nFail++;
                    $display("FAIL fp_starve_write: rw/mtr/wr=%b/%0d/%0d required 1/5/7",
                             rwF, mtrF, wrF);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        doReset();
        hold = 1'b0; req = 4'b0100; src2 = 3'd5; dst2 = 5'd17;
        src1 = 3'd3; dst1 = 5'd12;
        #2;
        nAssert++;
        if (gntR !== 4'b0100) begin
            nFail++;
            $display("FAIL mid_gnt: gnt=%b required 0100", gntR);
        end
        reset = 1'b0;
        #1;
        nAssert++;
        if ({gntR, mtrR, rwR, wrR, stR} !== 14'd0) begin
            nFail++;
            $display("FAIL mid_reset_async: outputs=%b required all zero", {gntR, mtrR, rwR, wrR, stR});
        end
        tick();
        nAssert++;
        if ({rwR, wrR} !== 6'd0) begin
            nFail++;
            $display("FAIL mid_discard: rw/wr=%b/%0d required 0/0", rwR, wrR);
        end
        reset = 1'b1; req = 4'b1010;
        #2;
        nAssert++;
        if ({gntR, rwR} !== {4'b0010, 1'b0}) begin
            nFail++;
            $display("FAIL post_reset_ptr: gnt/rw=%b/%b required 0010/0", gntR, rwR);
        end
        tick();
        req = 4'b0000;
        nAssert++;
        if ({rwR, mtrR, wrR} !== {1'b1, 3'd3, 5'd12}) begin
            nFail++;
            $display("FAIL post_reset_write: rw/mtr/wr=%b/%0d/%0d required 1/3/12", rwR, mtrR, wrR);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rr_sequence();
        test_single();
        test_zero_dst();
        test_hold_starve();
        test_fixed_priority();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end

endmodule
